// File: rtl/icache_line_store_if.sv
// ---------------------------------------------------------------------------
// icache_line_store_if
//   Bus between the instruction-cache controller and the line store.
//   One shared line select addresses both the data array and the tag array,
//   for reads and writes alike; the mini (lock-down) array has its own select.
//
//   Signals (controller view):
//     line_sel    out  SEL_W     line address for data + tag arrays
//     data_we     out  1         data-array write enable
//     data_wdata  out  LINE_W    full line to write
//     data_rdata  in   LINE_W    data line at line_sel (combinational)
//     tag_we      out  1         tag-array write enable
//     tag_wdata   out  TAG_W     tag entry to write {D, V, IA[31:14]}
//     tag_rdata   in   TAG_W     tag entry at line_sel (combinational)
//     mini_sel    out  MINI_SEL  mini-array line address
//     mini_rdata  in   LINE_W    mini line at mini_sel (combinational)
//
//   Modports: master = cache controller, slave = line store.
// ---------------------------------------------------------------------------
interface icache_line_store_if #(
   parameter int LINE_W   = 256,
   parameter int SEL_W    = 9,
   parameter int TAG_W    = 20,
   parameter int MINI_SEL = 4
);

   logic [SEL_W-1:0]    line_sel;
   logic                data_we;
   logic [LINE_W-1:0]   data_wdata;
   logic [LINE_W-1:0]   data_rdata;
   logic                tag_we;
   logic [TAG_W-1:0]    tag_wdata;
   logic [TAG_W-1:0]    tag_rdata;
   logic [MINI_SEL-1:0] mini_sel;
   logic [LINE_W-1:0]   mini_rdata;

   modport master (
      output line_sel,
      output data_we,
      output data_wdata,
      input  data_rdata,
      output tag_we,
      output tag_wdata,
      input  tag_rdata,
      output mini_sel,
      input  mini_rdata
   );

   modport slave (
      input  line_sel,
      input  data_we,
      input  data_wdata,
      output data_rdata,
      input  tag_we,
      input  tag_wdata,
      output tag_rdata,
      input  mini_sel,
      output mini_rdata
   );

endinterface

// File: rtl/icache_line_store.sv
// ---------------------------------------------------------------------------
// icache_line_store
//   Storage core of the instruction cache:
//     - data array : 2**SEL_W lines x LINE_W bits, no reset
//     - tag array  : 2**SEL_W entries x TAG_W bits, entry = {D, V, IA[31:14]}
//                    D and IA live in a plain RAM (no reset); V lives in a
//                    flop vector cleared asynchronously by nRESET
//     - mini array : 16 x LINE_W read-only lock-down lines (fixed pattern)
//   All reads are combinational; all writes happen on the rising edge of
//   nGCLK. There is no write-data bypass: a read in the write cycle returns
//   the old contents, the new value appears right after the edge.
//
//   Ports:
//     nGCLK    in   global clock, writes on its rising edge
//     nRESET   in   asynchronous active-low reset (clears V bits only and
//                   blocks writes while low)
//     bus      slave modport of icache_line_store_if
// ---------------------------------------------------------------------------
module icache_line_store #(
   parameter int    LINE_W    = 256,
   parameter int    SEL_W     = 9,
   parameter int    TAG_W     = 20,
   parameter int    MINI_SEL  = 4,
   parameter string MINI_INIT = ""
) (
   input  logic                  nGCLK,
   input  logic                  nRESET,
   icache_line_store_if.slave    bus
);

   localparam int          LINES     = 1 << SEL_W;
   localparam int          NWORDS    = LINE_W / 32;
   localparam int          VBIT      = TAG_W - 2;
   localparam logic [31:0] MINI_BASE = 32'hE1A0_0000;

   // The mini array is realised as logic from its fixed pattern; an external
   // image cannot be loaded without a simulation-only initialiser, so a
   // non-empty file name is rejected at elaboration instead of being ignored.
   if (MINI_INIT != "") begin : g_mini_init_check
      $error("icache_line_store: MINI_INIT image loading is not supported, leave it empty");
   end

   // ------------------------------------------------------------------------
   // Data array
   // ------------------------------------------------------------------------
   logic [LINE_W-1:0] data_mem_q [LINES];

   // Writes are qualified by nRESET so a write coinciding with reset is lost.
   always_ff @(posedge nGCLK) begin
      if (nRESET && bus.data_we) begin
         data_mem_q[bus.line_sel] <= bus.data_wdata;
      end
   end

   assign bus.data_rdata = data_mem_q[bus.line_sel];

   // ------------------------------------------------------------------------
   // Tag array: {D, IA} in RAM, V in resettable flops
   // ------------------------------------------------------------------------
   logic [TAG_W-2:0] tag_mem_q [LINES];
   logic [LINES-1:0] vld_q;
   logic [LINES-1:0] vld_d;
   logic [TAG_W-2:0] tag_wr_word;
   logic [TAG_W-2:0] tag_rd_word;

   // RAM word packs D above the IA field; V is stripped out.
   assign tag_wr_word = {bus.tag_wdata[TAG_W-1], bus.tag_wdata[VBIT-1:0]};

   always_ff @(posedge nGCLK) begin
      if (nRESET && bus.tag_we) begin
         tag_mem_q[bus.line_sel] <= tag_wr_word;
      end
   end

   always_comb begin
      vld_d = vld_q;
      if (bus.tag_we) begin
         vld_d[bus.line_sel] = bus.tag_wdata[VBIT];
      end
   end

   always_ff @(posedge nGCLK or negedge nRESET) begin
      if (!nRESET) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign tag_rd_word   = tag_mem_q[bus.line_sel];
   assign bus.tag_rdata = {tag_rd_word[TAG_W-2], vld_q[bus.line_sel], tag_rd_word[VBIT-1:0]};

   // ------------------------------------------------------------------------
   // Mini (lock-down) array: word j of line k = E1A0_0000 | k<<4 | j
   // ------------------------------------------------------------------------
   logic [LINE_W-1:0] mini_line;

   always_comb begin
      mini_line = '0;
      for (int j = 0; j < NWORDS; j++) begin
         mini_line[32*j +: 32] = MINI_BASE | 32'({bus.mini_sel, 4'(j)});
      end
   end

   assign bus.mini_rdata = mini_line;

endmodule

// File: tb/tb_icache_line_store.sv
module tb_icache_line_store;

   localparam int LINE_W   = 256;
   localparam int SEL_W    = 9;
   localparam int TAG_W    = 20;
   localparam int MINI_SEL = 4;
   localparam int LINES    = 512;

   logic nGCLK  = 1'b0;
   logic nRESET = 1'b0;

   always #5 nGCLK = ~nGCLK;

   icache_line_store_if #(
      .LINE_W(LINE_W), .SEL_W(SEL_W), .TAG_W(TAG_W), .MINI_SEL(MINI_SEL)
   ) bus ();

   icache_line_store #(
      .LINE_W(LINE_W), .SEL_W(SEL_W), .TAG_W(TAG_W), .MINI_SEL(MINI_SEL), .MINI_INIT("")
   ) dut (
      .nGCLK (nGCLK),
      .nRESET(nRESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (arrays + written flags) --------------
   logic [LINE_W-1:0] m_data [LINES];
   bit               m_data_ok [LINES];
   logic [TAG_W-1:0] m_tag [LINES];
   bit               m_tag_ok [LINES];
   bit               m_vld [LINES];

   function automatic logic [LINE_W-1:0] mini_exp(input int k);
      logic [LINE_W-1:0] l;
      for (int j = 0; j < 8; j++) l[32*j +: 32] = 32'hE1A0_0000 | 32'(k << 4) | 32'(j);
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] f_line(input int i);
      logic [LINE_W-1:0] l;
      for (int j = 0; j < 8; j++) l[32*j +: 32] = (32'(i) * 32'h0001_0003) ^ (32'(j) << 28);
      return l;
   endfunction

   function automatic logic [TAG_W-1:0] g_tag(input int i);
      logic [8:0] b;
      b = 9'(i);
      return {b[0], b[1], 18'(i * 7 + 3)};
   endfunction

   always @(posedge nGCLK or negedge nRESET) begin
      if (!nRESET) begin
         for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
      end else begin
         if (bus.data_we) begin
            m_data[int'(bus.line_sel)]    = bus.data_wdata;
            m_data_ok[int'(bus.line_sel)] = 1'b1;
         end
         if (bus.tag_we) begin
            m_tag[int'(bus.line_sel)]    = bus.tag_wdata;
            m_tag_ok[int'(bus.line_sel)] = 1'b1;
            m_vld[int'(bus.line_sel)]    = bus.tag_wdata[18];
         end
      end
   end

   // ---------------- per-cycle compare against the model ------------------
   always @(negedge nGCLK) begin
      int ls;
      ls = int'(bus.line_sel);
      check("tag_v", LINE_W'(bus.tag_rdata[18]), LINE_W'(m_vld[ls]));
      if (m_tag_ok[ls])
         check("tag_d_ia", LINE_W'({bus.tag_rdata[19], bus.tag_rdata[17:0]}),
               LINE_W'({m_tag[ls][19], m_tag[ls][17:0]}));
      if (m_data_ok[ls]) check("data", bus.data_rdata, m_data[ls]);
      check("mini", bus.mini_rdata, mini_exp(int'(bus.mini_sel)));
   end

   task automatic step();
      @(posedge nGCLK);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [LINE_W-1:0] l0, old_l, new_l, d55;

   initial begin
      bus.line_sel   = '0;
      bus.data_we    = 1'b0;
      bus.data_wdata = '0;
      bus.tag_we     = 1'b0;
      bus.tag_wdata  = '0;
      bus.mini_sel   = '0;
      nRESET         = 1'b0;
      repeat (3) step();
      nRESET = 1'b1;
      step();

      // 1) reset state of V, then a single tag write
      for (int i = 0; i < LINES; i++) begin
         bus.line_sel = 9'(i);
         @(negedge nGCLK);
         check("rst_v_zero", LINE_W'(bus.tag_rdata[18]), '0);
         step();
      end
      bus.line_sel  = 9'd9;
      bus.tag_we    = 1'b1;
      bus.tag_wdata = 20'h4_ABCD;
      step();
      bus.tag_we = 1'b0;
      @(negedge nGCLK);
      check("tag9_lit", LINE_W'(bus.tag_rdata), LINE_W'(20'h4_ABCD));
      step();
      for (int i = 0; i < LINES; i++) begin
         bus.line_sel = 9'(i);
         #1;
         check("v_only_9", LINE_W'(bus.tag_rdata[18]), LINE_W'(i == 9));
      end

      // 2) read-during-write on the top line, line 0 untouched
      for (int j = 0; j < 8; j++) begin
         l0[32*j +: 32]    = 32'h0000_1111;
         old_l[32*j +: 32] = 32'h0BAD_F00D;
         new_l[32*j +: 32] = 32'hDEAD_0000 + 32'(j);
      end
      bus.line_sel   = 9'd0;
      bus.data_we    = 1'b1;
      bus.data_wdata = l0;
      step();
      bus.line_sel   = 9'h1FF;
      bus.data_wdata = old_l;
      step();
      bus.data_wdata = new_l;
      @(negedge nGCLK);
      check("rdw_old", bus.data_rdata, old_l);
      step();
      bus.data_we = 1'b0;
      @(negedge nGCLK);
      check("rdw_new", bus.data_rdata, new_l);
      check("rdw_word7", LINE_W'(bus.data_rdata[255:224]), LINE_W'(32'hDEAD_0007));
      step();
      bus.line_sel = 9'd0;
      #1;
      check("line0_kept", bus.data_rdata, l0);

      // 3) simultaneous data+tag write, then tag-only V=0
      for (int j = 0; j < 8; j++) d55[32*j +: 32] = 32'h5500_0000 | 32'(j * 3);
      step();
      bus.line_sel   = 9'h055;
      bus.data_we    = 1'b1;
      bus.tag_we     = 1'b1;
      bus.data_wdata = d55;
      bus.tag_wdata  = 20'hC_1357;
      step();
      bus.data_we = 1'b0;
      bus.tag_we  = 1'b0;
      @(negedge nGCLK);
      check("both_data", bus.data_rdata, d55);
      check("both_tag", LINE_W'(bus.tag_rdata), LINE_W'(20'hC_1357));
      step();
      bus.tag_we    = 1'b1;
      bus.tag_wdata = 20'h8_2468;
      step();
      bus.tag_we = 1'b0;
      @(negedge nGCLK);
      check("tag_v0", LINE_W'(bus.tag_rdata), LINE_W'(20'h8_2468));
      check("data_after_tag", bus.data_rdata, d55);

      // 4) reset coinciding with a tag write to line 3
      step();
      bus.line_sel  = 9'd3;
      bus.tag_we    = 1'b1;
      bus.tag_wdata = 20'h7_FFFF;
      #2 nRESET = 1'b0;
      step();
      step();
      @(negedge nGCLK);
      check("rst_line3_v", LINE_W'(bus.tag_rdata[18]), '0);
      step();
      bus.tag_we = 1'b0;
      nRESET     = 1'b1;
      @(negedge nGCLK);
      check("post_rst_line3_v", LINE_W'(bus.tag_rdata[18]), '0);
      bus.line_sel = 9'd9;
      #1;
      check("post_rst_line9_v", LINE_W'(bus.tag_rdata[18]), '0);
      bus.line_sel = 9'h055;
      #1;
      check("post_rst_data", bus.data_rdata, d55);

      // 5) mini sweep while other activity continues
      for (int k = 0; k < 16; k++) begin
         bus.mini_sel   = 4'(k);
         bus.line_sel   = 9'($urandom_range(0, 511));
         bus.data_we    = 1'($urandom_range(0, 1));
         bus.data_wdata = {8{$urandom}};
         @(negedge nGCLK);
         if (k == 5)  check("mini_5_2", LINE_W'(bus.mini_rdata[95:64]), LINE_W'(32'hE1A0_0052));
         if (k == 15) check("mini_15_7", LINE_W'(bus.mini_rdata[255:224]), LINE_W'(32'hE1A0_00F7));
         step();
      end
      bus.data_we = 1'b0;

      // 6) fill every line with a distinct value, then read all back
      for (int i = 0; i < LINES; i++) begin
         bus.line_sel   = 9'(i);
         bus.data_we    = 1'b1;
         bus.tag_we     = 1'b1;
         bus.data_wdata = f_line(i);
         bus.tag_wdata  = g_tag(i);
         step();
      end
      bus.data_we = 1'b0;
      bus.tag_we  = 1'b0;
      for (int i = 0; i < LINES; i++) begin
         bus.line_sel = 9'(i);
         #1;
         check("fill_data", bus.data_rdata, f_line(i));
         check("fill_tag", LINE_W'(bus.tag_rdata), LINE_W'(g_tag(i)));
      end
      step();

      // random traffic, including occasional reset pulses
      for (int c = 0; c < 2000; c++) begin
         bus.line_sel   = 9'($urandom_range(0, 511));
         bus.mini_sel   = 4'($urandom_range(0, 15));
         bus.data_we    = ($urandom_range(0, 3) == 0);
         bus.tag_we     = ($urandom_range(0, 3) == 0);
         bus.data_wdata = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
         bus.tag_wdata  = 20'($urandom);
         nRESET         = ($urandom_range(0, 199) != 0);
         step();
      end
      nRESET      = 1'b1;
      bus.data_we = 1'b0;
      bus.tag_we  = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
